iter_alu: RTL and testbench

- Parametrised, registered successor to the datapath's single-cycle 32-bit ALU.
- Keeps the add/sub/and/or/slt/sll opcodes, completed in one cycle.
- Adds iterative multi-cycle multiply and unsigned divide, behind a valid/ready input handshake and a one-cycle out_valid pulse.
- Sits in the EX stage; the controller stalls on in_ready low.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/iter_muldiv.sv | 90 +++++++++
 rtl/iter_alu.sv | 94 +++++++++
 tb/tb_iter_alu.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: opcodes, FSM states and the
// multi-cycle opcode classifier. Honours ALU_DIV_EN (DIVU hardware present).
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_DIVU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Without divider hardware, DIVU falls through to the one-cycle unknown-op path.
  function automatic logic is_multicycle(input logic [2:0] op);
`ifdef ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_DIVU);
`else
    return (op == OP_MUL);
`endif
  endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative shift-add multiplier and (with ALU_DIV_EN) restoring unsigned
// divider. One iteration per step; res_next is the value after the current
// step so the top can register the final result on the last step's edge.
module iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef ALU_DIV_EN
  input  logic             div_sel,
`endif
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last_iter,
  output logic [WIDTH-1:0] res_next
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  // acc: product accumulator / remainder; sh: multiplicand / dividend->quotient;
  // opb: multiplier (shifted right) / divisor (held).
  logic [WIDTH-1:0] acc, sh, opb;
  logic [WIDTH-1:0] acc_nx, sh_nx, opb_nx;
  logic [SHW-1:0]   cnt;

`ifdef ALU_DIV_EN
  logic             mode_div;
  logic [WIDTH:0]   rem_s, diff;
`endif

  assign last_iter = (cnt == LAST);

  // One iteration of whichever algorithm is selected.
  always_comb begin
    acc_nx = opb[0] ? acc + sh : acc;
    sh_nx  = sh << 1;
    opb_nx = opb >> 1;
`ifdef ALU_DIV_EN
    rem_s = {acc, sh[WIDTH-1]};
    diff  = rem_s - {1'b0, opb};
    if (mode_div) begin
      opb_nx = opb;
      // Compare rather than test the borrow so b == 0 always subtracts,
      // giving an all-ones quotient.
      if (rem_s >= {1'b0, opb}) begin
        acc_nx = diff[WIDTH-1:0];
        sh_nx  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_s[WIDTH-1:0];
        sh_nx  = {sh[WIDTH-2:0], 1'b0};
      end
    end
    res_next = mode_div ? sh_nx : acc_nx;
`else
    res_next = acc_nx;
`endif
  end

  // Operand load on start, then one iteration per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      sh  <= '0;
      opb <= '0;
      cnt <= '0;
`ifdef ALU_DIV_EN
      mode_div <= 1'b0;
`endif
    end else if (start) begin
      acc <= '0;
      sh  <= a;
      opb <= b;
      cnt <= '0;
`ifdef ALU_DIV_EN
      mode_div <= div_sel;
`endif
    end else if (step) begin
      acc <= acc_nx;
      sh  <= sh_nx;
      opb <= opb_nx;
      cnt <= last_iter ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Registered EX-stage ALU: one-cycle simple ops plus iterative MUL and
// (when ALU_DIV_EN is defined) DIVU behind a valid/ready handshake.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state, state_nx;
  logic             accept, start, last_iter;
  logic [WIDTH-1:0] simple_res, md_res;

  assign in_ready  = (state == ST_IDLE) || (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign start     = accept && is_multicycle(op);
  assign busy      = (state == ST_ITER);
  assign out_valid = (state == ST_DONE);

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef ALU_DIV_EN
    .div_sel   (op == OP_DIVU),
`endif
    .step      (busy),
    .a         (a),
    .b         (b),
    .last_iter (last_iter),
    .res_next  (md_res)
  );

  // Single-cycle operations; anything else (incl. multi-cycle ops) yields 0.
  always_comb begin
    simple_res = '0;
    case (op)
      OP_ADD:  simple_res = a + b;
      OP_SUB:  simple_res = a - b;
      OP_AND:  simple_res = a & b;
      OP_OR:   simple_res = a | b;
      OP_SLT:  simple_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  simple_res = b << a[SHW-1:0];
      default: simple_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state: DONE accepts exactly like IDLE, ITER runs until last_iter.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept) state_nx = is_multicycle(op) ? ST_ITER : ST_DONE;
        else        state_nx = ST_IDLE;
      end
      ST_ITER: if (last_iter) state_nx = ST_DONE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Output registers load only on DONE entry and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      zero   <= 1'b1;
    end else if (accept && !start) begin
      result <= simple_res;
      zero   <= (simple_res == '0);
    end else if (busy && last_iter) begin
      result <= md_res;
      zero   <= (md_res == '0);
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu (WIDTH=32). Expected values come from a
// plain arithmetic model; DIVU expectations follow ALU_DIV_EN.
module tb_iter_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid;
  logic [2:0]   op;
  logic [W-1:0] a, b, result;
  logic         in_ready, out_valid, zero, busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .result(result),
    .zero(zero), .busy(busy)
  );

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x * y;
      3'd5: return (x < y) ? 1 : 0;
      3'd6: return y << (x % W);
`ifdef ALU_DIV_EN
      3'd7: return (y == 0) ? {W{1'b1}} : x / y;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o);
`ifdef ALU_DIV_EN
    if (o == 3'd7) return W + 1;
`endif
    return (o == 3'd4) ? W + 1 : 1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op at a negedge (in_ready assumed high), wait for out_valid.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int lat;
    logic stall_ok;
    logic [W-1:0] e;
    e = model(o, x, y);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    stall_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "/lat"}, lat, model_lat(o));
    chk({tag, "/res"}, result, e);
    chk({tag, "/zero"}, {31'd0, zero}, {31'd0, (e == 0)});
    if (model_lat(o) > 1) chk({tag, "/busy"}, {31'd0, stall_ok}, 1);
  endtask

  logic [2:0]   simple_ops [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
  logic [2:0]   ro;
  logic [W-1:0] rx, ry, ev;
  logic         seen;
  int           lat;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset/flags", {28'd0, out_valid, busy, in_ready, zero}, 4'b0011);
    chk("reset/res", result, 0);
    rst = 1'b0;

    run_op("add5_7", 3'd0, 5, 7);
    run_op("sub9_9", 3'd1, 9, 9);
    run_op("mul", 3'd4, 32'h0001_0000, 32'h0003_0001);
    run_op("divu100_7", 3'd7, 100, 7);
    run_op("divu5_0", 3'd7, 5, 0);
    run_op("slt", 3'd5, 32'hFFFF_FFFF, 1);
    run_op("sll", 3'd6, 32'h21, 1);

    // Reset during iteration 10 of a MUL.
    op = 3'd4; a = 32'h1234; b = 32'h5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/flags", {28'd0, out_valid, busy, in_ready, zero}, 4'b0011);
    chk("midrst/res", result, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("midrst/no_valid", {31'd0, seen}, 0);
    run_op("add1_1", 3'd0, 1, 1);

    // Back-to-back simple ops.
    for (int i = 0; i < 8; i++) begin
      ro = simple_ops[$urandom_range(0, 5)];
      op = ro; a = $urandom; b = $urandom; in_valid = 1'b1;
      ev = model(ro, a, b);
      @(negedge clk);
      chk($sformatf("thru%0d/valid", i), {31'd0, out_valid}, 1);
      chk($sformatf("thru%0d/res", i), result, ev);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("thru/end", {31'd0, out_valid}, 0);

    // Requests while busy are ignored.
    rx = $urandom; ry = $urandom;
    op = 3'd4; a = rx; b = ry; in_valid = 1'b1;
    @(negedge clk);
    op = 3'd0; a = 1; b = 2;
    repeat (4) @(negedge clk);
    op = 3'd4; a = 7; b = 9;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    lat = 9;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("ign/lat", lat, W + 1);
    chk("ign/res", result, rx * ry);
    @(negedge clk);
    chk("ign/no_extra", {31'd0, out_valid}, 0);

    // Random mix of all opcodes.
    repeat (30) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 0 : $urandom;
      if ($urandom_range(0, 1) == 1) rx = rx >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) ry = ry >> $urandom_range(0, 31);
      run_op($sformatf("rnd_op%0d", ro), ro, rx, ry);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
